// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory controller.
//   state_t        : controller state (CLEAR sweep, IDLE fetch, LOAD stream)
//   NOP_DEFAULT    : fill instruction written during the clear sweep
//   addr_in_range  : true when a word address falls inside the program array
package inst_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [15:0] NOP_DEFAULT = 16'b1000000001000000;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] length);
    return addr < length;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Plain 1R1W program RAM: synchronous write, asynchronous read. The
// controller registers the read data, so fetch latency stays one cycle.
//   clk     : rising-edge clock
//   we      : write enable
//   wr_addr : write word address (PCL bits)
//   wr_data : write data (WORD bits)
//   rd_addr : read word address (PCL bits)
//   rd_data : read data, zero for addresses outside the array
module inst_mem_array #(
  parameter int WORD   = 16,
  parameter int LENGTH = 1024,
  parameter int PCL    = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PCL-1:0]  wr_addr,
  input  logic [WORD-1:0] wr_data,
  input  logic [PCL-1:0]  rd_addr,
  output logic [WORD-1:0] rd_data
);

  localparam int           AW    = $clog2(LENGTH);
  localparam logic [PCL:0] DEPTH = (PCL+1)'(LENGTH);

  logic [WORD-1:0] mem [LENGTH];

  // NOTE: the array has no reset; the controller's clear sweep initialises
  // it, which keeps the storage mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wr_addr} < DEPTH)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr[AW-1:0]] : '0;
  end

endmodule

// File: rtl/inst_memory_ctrl.sv
// Synchronous instruction memory with fetch handshake and streaming loader.
// After reset it fills every word with NOP, then serves fetches from IDLE
// with one cycle of latency; load_start opens a streaming write from word 0.
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch_req    : fetch request, accepted only while fetch_ready=1
//   address      : fetch word address
//   fetch_ready  : high in IDLE
//   out          : registered instruction (holds when no fetch accepted)
//   out_valid    : out answers the fetch accepted on the previous edge
//   load_start   : begin a program load at word 0 (IDLE only)
//   load_valid   : load_data carries a word
//   load_data    : word to write
//   load_last    : qualifies load_valid, marks the final word
//   load_ready   : high in LOAD
//   load_done    : one-cycle pulse after the final word is written
//   load_count   : words written by the current or last load
//   busy         : controller is clearing or loading
module inst_memory_ctrl
  import inst_mem_pkg::*;
#(
  parameter int              WORD   = 16,
  parameter int              LENGTH = 1024,
  parameter int              PCL    = 10,
  parameter logic [WORD-1:0] NOP    = WORD'(NOP_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_req,
  input  logic [PCL-1:0]  address,
  output logic            fetch_ready,
  output logic [WORD-1:0] out,
  output logic            out_valid,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [WORD-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            load_done,
  output logic [PCL:0]    load_count,
  output logic            busy
);

  localparam logic [PCL:0] LAST_ADDR = (PCL+1)'(LENGTH-1);
  localparam logic [PCL:0] ONE       = (PCL+1)'(1);

  state_t          state_q, state_d;
  logic [PCL:0]    clr_addr_q;
  logic [PCL:0]    wr_addr_q;
  logic            mem_we;
  logic [PCL-1:0]  mem_waddr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;
  logic            fetch_accept;
  logic            load_accept;
  logic            load_final;

  assign fetch_accept = fetch_req & fetch_ready;
  assign load_accept  = load_valid & load_ready;
  // A load ends on load_last or when the last array word is written, so
  // load_ready drops before any word past the end can be accepted.
  assign load_final   = load_accept & (load_last | (wr_addr_q == LAST_ADDR));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      IDLE:    if (load_start)              state_d = LOAD;
      LOAD:    if (load_final)              state_d = IDLE;
      default:                              state_d = CLEAR;
    endcase
  end

  // State outputs and write-port mux (clear sweep vs load stream)
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    busy        = 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q[PCL-1:0];
    mem_wdata   = NOP;
    unique case (state_q)
      CLEAR: mem_we = 1'b1;
      IDLE: begin
        fetch_ready = 1'b1;
        busy        = 1'b0;
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        mem_waddr  = wr_addr_q[PCL-1:0];
        mem_wdata  = load_data;
      end
      default: ;
    endcase
  end

  // Clear and write counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      wr_addr_q  <= '0;
      load_count <= '0;
    end else begin
      if (state_q == CLEAR) clr_addr_q <= clr_addr_q + ONE;
      if ((state_q == IDLE) && load_start) begin
        wr_addr_q  <= '0;
        load_count <= '0;
      end else if (load_accept) begin
        wr_addr_q  <= wr_addr_q + ONE;
        load_count <= load_count + ONE;
      end
    end
  end

  // Output register: out holds its value between accepted fetches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= NOP;
      out_valid <= 1'b0;
      load_done <= 1'b0;
    end else begin
      out_valid <= fetch_accept;
      load_done <= load_final;
      if (fetch_accept) begin
        out <= addr_in_range(32'(address), 32'(LENGTH)) ? mem_rdata : NOP;
      end
    end
  end

  inst_mem_array #(
    .WORD   (WORD),
    .LENGTH (LENGTH),
    .PCL    (PCL)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_addr (address),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_inst_memory_ctrl.sv
// Randomised scoreboard bench for inst_memory_ctrl (LENGTH=16, PCL=5).
// The reference model is a plain word array; fetch responses are queued
// with the cycle they are due and checked by an independent monitor.
module tb_inst_memory_ctrl;
  import inst_mem_pkg::*;

  localparam int              WORD   = 16;
  localparam int              LENGTH = 16;
  localparam int              PCL    = 5;
  localparam logic [WORD-1:0] NOP    = 16'h8040;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            fetch_req = 1'b0;
  logic [PCL-1:0]  address = '0;
  logic            fetch_ready;
  logic [WORD-1:0] out;
  logic            out_valid;
  logic            load_start = 1'b0;
  logic            load_valid = 1'b0;
  logic [WORD-1:0] load_data = '0;
  logic            load_last = 1'b0;
  logic            load_ready;
  logic            load_done;
  logic [PCL:0]    load_count;
  logic            busy;

  inst_memory_ctrl #(
    .WORD(WORD), .LENGTH(LENGTH), .PCL(PCL), .NOP(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .address(address),
    .fetch_ready(fetch_ready), .out(out), .out_valid(out_valid),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     due;
    logic [WORD-1:0] data;
  } exp_t;

  int unsigned     cyc = 0;
  exp_t            sb[$];
  logic [WORD-1:0] ref_mem [LENGTH];
  logic [WORD-1:0] last_out_exp = NOP;
  int              n_checks = 0;
  int              n_pass = 0;
  int              done_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [WORD-1:0] model_read(input int a);
    return (a < LENGTH) ? ref_mem[a] : NOP;
  endfunction

  // Monitor: every out_valid must match the oldest queued expectation, on time
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (load_done) done_pulses++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("fetch_latency", cyc, e.due);
          check("fetch_data", 32'(out), 32'(e.data));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("missing_out_valid", 32'(out_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called only when the DUT is known (from the model) to be in IDLE next edge
  task automatic push_fetch(input int a);
    exp_t e;
    e.due  = cyc + 1;
    e.data = model_read(a);
    sb.push_back(e);
    last_out_exp = e.data;
  endtask

  task automatic fetch_list(input int addrs[$]);
    foreach (addrs[i]) begin
      fetch_req = 1'b1;
      address   = PCL'(addrs[i]);
      push_fetch(addrs[i]);
      step();
    end
    fetch_req = 1'b0;
  endtask

  task automatic fetch_all_words();
    int addrs[$];
    for (int i = 0; i < LENGTH; i++) addrs.push_back(i);
    fetch_list(addrs);
  endtask

  task automatic random_fetches(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        a = int'($urandom_range(0, (1 << PCL) - 1));
        fetch_req = 1'b1;
        address   = PCL'(a);
        push_fetch(a);
      end else begin
        fetch_req = 1'b0;
      end
      step();
    end
    fetch_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out"},         32'(out),         32'(NOP));
    check({tag, "_out_valid"},   32'(out_valid),   32'd0);
    check({tag, "_load_done"},   32'(load_done),   32'd0);
    check({tag, "_load_count"},  32'(load_count),  32'd0);
    check({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd0);
    check({tag, "_load_ready"},  32'(load_ready),  32'd0);
    check({tag, "_busy"},        32'(busy),        32'd1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LENGTH; i++) ref_mem[i] = NOP;
    sb.delete();
    last_out_exp = NOP;
  endtask

  // Releases reset and runs through the clear sweep with fetch_req and
  // load_start held high; neither may take effect while busy.
  task automatic release_and_clear(input string tag);
    int n = 0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    fetch_req  = 1'b1;
    load_start = 1'b1;
    address    = PCL'($urandom_range(0, LENGTH - 1));
    do begin
      step();
      n++;
      if (busy) check({tag, "_stall_out_valid"}, 32'(out_valid), 32'd0);
    end while (busy && n < 4 * LENGTH);
    fetch_req  = 1'b0;
    load_start = 1'b0;
    check({tag, "_clear_cycles"}, 32'(n), 32'(LENGTH));
    check({tag, "_fetch_ready"},  32'(fetch_ready), 32'd1);
    check({tag, "_no_load"},      32'(load_ready), 32'd0);
    check({tag, "_out_held"},     32'(out), 32'(last_out_exp));
  endtask

  task automatic do_load(input logic [WORD-1:0] words[$], input int last_idx,
                         input bit rand_gaps, input bit fetch_at_start,
                         input int fetch_addr);
    bit active = 1'b1;
    int wa = 0;
    int exp_done = 0;
    int done_before;
    int i = 0;
    load_start = 1'b1;
    if (fetch_at_start) begin
      fetch_req = 1'b1;
      address   = PCL'(fetch_addr);
      push_fetch(fetch_addr);
    end
    step();
    load_start  = 1'b0;
    fetch_req   = 1'b0;
    done_before = done_pulses;
    check("load_entered", 32'(load_ready), 32'd1);
    check("load_count_start", 32'(load_count), 32'd0);
    while (i < words.size()) begin
      // fetch_req rides along only while the model says LOAD (must stall)
      fetch_req = active;
      address   = PCL'($urandom_range(0, LENGTH - 1));
      if (rand_gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        load_last  = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data  = words[i];
        load_last  = (i == last_idx);
        if (active) begin
          ref_mem[wa] = words[i];
          wa++;
          if (i == last_idx || wa == LENGTH) begin
            active = 1'b0;
            exp_done++;
          end
        end
        i++;
      end
      step();
      if (!active) check("load_ready_closed", 32'(load_ready), 32'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    step();
    check("load_done_pulses", 32'(done_pulses - done_before), 32'(exp_done));
    check("load_count", 32'(load_count), 32'(wa));
    check("load_idle", 32'(busy), 32'd0);
    check("load_out_held", 32'(out), 32'(last_out_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WORD-1:0] words[$];
    int len, last_idx;

    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(posedge clk);
    release_and_clear("clear1");
    fetch_all_words();

    // Four words, fetch to word 5 issued together with load_start
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_load(words, 3, 1'b0, 1'b1, 5);
    fetch_list('{0, 1, 2, 3, 4});

    // Overflow: 20 words, no load_last; only LENGTH may land
    words.delete();
    for (int k = 0; k < LENGTH + 4; k++) words.push_back(WORD'($urandom));
    do_load(words, -1, 1'b0, 1'b0, 0);
    fetch_all_words();

    // Out-of-range addresses return NOP
    fetch_list('{20, 31, 16, 3});

    // Random loads with gaps, then random fetches
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, LENGTH + 2));
      last_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
      if (last_idx < 0 && len < LENGTH) last_idx = len - 1;
      words.delete();
      for (int k = 0; k < len; k++) words.push_back(WORD'($urandom));
      do_load(words, last_idx, 1'b1, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, (1 << PCL) - 1)));
      random_fetches(40);
    end

    // Reset in the middle of a load
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    step();
    load_data  = 16'hBBBB;
    step();
    load_data  = 16'hCCCC;
    check("midload_count", 32'(load_count), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midload_reset");
    load_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    release_and_clear("clear2");
    fetch_list('{0, 1, 2});

    step();
    step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
